// File: rtl/game_pkg.sv
// Shared types and constants for the game state controller: FSM state codes,
// sprite box size and default frame counts.
package game_pkg;
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PLAY  = 3'd1;
  localparam state_t ST_POWER = 3'd2;
  localparam state_t ST_DYING = 3'd3;
  localparam state_t ST_OVER  = 3'd4;

  localparam int SPRITE_SIZE      = 8;
  localparam int POWER_FRAMES_DEF = 300;
  localparam int DYING_FRAMES_DEF = 60;
  localparam int LIVES_INIT_DEF   = 3;
  localparam int CNT_W            = 16;
endpackage

// File: rtl/box_overlap.sv
// Combinational overlap test of two SPRITE_SIZE square boxes given by their
// top-left corners; hit when both axis distances are below the box size.
module box_overlap
  import game_pkg::*;
(
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  output logic       hit
);
  localparam logic signed [10:0] LIM = 11'(SPRITE_SIZE);

  logic signed [10:0] dx;
  logic signed [10:0] dy;

  assign dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
  assign dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
  assign hit = (dx < LIM) && (dx > -LIM) && (dy < LIM) && (dy > -LIM);
endmodule

// File: rtl/game_state_ctrl.sv
// Pacman game FSM: collisions, power mode, deaths and lives, advanced once per frame_tick.
// Outputs are registered on the frame_tick edge; define POWER_BLINK_EN to blink reversal near power end.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int POWER_FRAMES = POWER_FRAMES_DEF,
  parameter int DYING_FRAMES = DYING_FRAMES_DEF,
  parameter int LIVES_INIT   = LIVES_INIT_DEF
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_tick,
  input  logic            start,
  input  logic [9:0]      pacmanX,
  input  logic [9:0]      pacmanY,
  input  logic [9:0]      ghost_redX,
  input  logic [9:0]      ghost_redY,
  input  logic [9:0]      ghost_greenX,
  input  logic [9:0]      ghost_greenY,
  input  logic [9:0]      ghost_aquaX,
  input  logic [9:0]      ghost_aquaY,
  input  logic [5:0][9:0] fruit_location,
  output logic            death,
  output logic            reversal,
  output logic            closePacman,
  output logic            first_on,
  output logic            second_on,
  output logic            third_on,
  output logic            respawn,
  output logic [2:0]      ghost_eaten,
  output logic [1:0]      lives
);
  state_t            state_q, state_d;
  logic [1:0]        lives_q, lives_d;
  logic [CNT_W-1:0]  power_cnt_q, power_cnt_d;
  logic [CNT_W-1:0]  dying_cnt_q, dying_cnt_d;
  logic [2:0]        frame_cnt_q, frame_cnt_d;
  logic              close_q, close_d;
  logic [2:0]        fruit_q, fruit_d;
  logic              respawn_q, respawn_d;
  logic [2:0]        eaten_q, eaten_d;

  logic [2:0]        fruit_hit;
  logic [2:0]        ghost_hit;
  logic [2:0]        fruit_eat;

  // fruit_location is packed {X0,Y0,X1,Y1,X2,Y2}, so X0 sits in the top slot
  box_overlap u_fruit0 (.ax(pacmanX), .ay(pacmanY), .bx(fruit_location[5]), .by(fruit_location[4]), .hit(fruit_hit[0]));
  box_overlap u_fruit1 (.ax(pacmanX), .ay(pacmanY), .bx(fruit_location[3]), .by(fruit_location[2]), .hit(fruit_hit[1]));
  box_overlap u_fruit2 (.ax(pacmanX), .ay(pacmanY), .bx(fruit_location[1]), .by(fruit_location[0]), .hit(fruit_hit[2]));
  box_overlap u_red    (.ax(pacmanX), .ay(pacmanY), .bx(ghost_redX),   .by(ghost_redY),   .hit(ghost_hit[0]));
  box_overlap u_green  (.ax(pacmanX), .ay(pacmanY), .bx(ghost_greenX), .by(ghost_greenY), .hit(ghost_hit[1]));
  box_overlap u_aqua   (.ax(pacmanX), .ay(pacmanY), .bx(ghost_aquaX),  .by(ghost_aquaY),  .hit(ghost_hit[2]));

  assign fruit_eat = fruit_hit & fruit_q;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    power_cnt_d = power_cnt_q;
    dying_cnt_d = dying_cnt_q;
    frame_cnt_d = frame_cnt_q;
    close_d     = close_q;
    fruit_d     = fruit_q;
    respawn_d   = 1'b0;
    eaten_d     = 3'b000;
    if (frame_tick) begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_d     = ST_PLAY;
            fruit_d     = 3'b111;
            lives_d     = 2'(LIVES_INIT);
            frame_cnt_d = 3'd0;
            close_d     = 1'b0;
            power_cnt_d = '0;
            dying_cnt_d = '0;
            respawn_d   = 1'b1;
          end
        end
        ST_PLAY, ST_POWER: begin
          frame_cnt_d = frame_cnt_q + 3'd1;
          if (frame_cnt_q == 3'd7) close_d = ~close_q;
          fruit_d = fruit_q & ~fruit_eat;
          // A fruit taken this frame wins over a ghost contact in the same frame
          if (|fruit_eat) begin
            state_d     = ST_POWER;
            power_cnt_d = CNT_W'(POWER_FRAMES - 1);
            eaten_d     = ghost_hit;
          end else if (state_q == ST_POWER) begin
            eaten_d = ghost_hit;
            if (power_cnt_q == '0) state_d = ST_PLAY;
            else                   power_cnt_d = power_cnt_q - 1'b1;
          end else if (|ghost_hit) begin
            state_d     = ST_DYING;
            lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            dying_cnt_d = CNT_W'(DYING_FRAMES - 1);
            close_d     = 1'b0;
          end
        end
        ST_DYING: begin
          if (dying_cnt_q == '0) begin
            if (lives_q == 2'd0) begin
              state_d = ST_OVER;
            end else begin
              state_d   = ST_PLAY;
              respawn_d = 1'b1;
            end
          end else begin
            dying_cnt_d = dying_cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      lives_q     <= 2'd0;
      power_cnt_q <= '0;
      dying_cnt_q <= '0;
      frame_cnt_q <= 3'd0;
      close_q     <= 1'b0;
      fruit_q     <= 3'b000;
      respawn_q   <= 1'b0;
      eaten_q     <= 3'b000;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      power_cnt_q <= power_cnt_d;
      dying_cnt_q <= dying_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      close_q     <= close_d;
      fruit_q     <= fruit_d;
      respawn_q   <= respawn_d;
      eaten_q     <= eaten_d;
    end
  end

  assign death       = (state_q == ST_OVER);
`ifdef POWER_BLINK_EN
  assign reversal    = (state_q == ST_POWER) && ((power_cnt_q >= CNT_W'(64)) || power_cnt_q[3]);
`else
  assign reversal    = (state_q == ST_POWER);
`endif
  assign closePacman = close_q;
  assign first_on    = fruit_q[0];
  assign second_on   = fruit_q[1];
  assign third_on    = fruit_q[2];
  assign respawn     = respawn_q;
  assign ghost_eaten = eaten_q;
  assign lives       = lives_q;
endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed vector table, multi-frame corner sequences,
// and a randomized run against a frame-timestamp reference model.
module tb_game_state_ctrl;
  localparam int PF = 300;
  localparam int DF = 60;
  localparam int LI = 3;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            frame_tick = 1'b0;
  logic            start = 1'b0;
  logic [9:0]      pacmanX, pacmanY;
  logic [9:0]      ghost_redX, ghost_redY, ghost_greenX, ghost_greenY, ghost_aquaX, ghost_aquaY;
  logic [5:0][9:0] fruit_location;
  logic            death, reversal, closePacman, first_on, second_on, third_on, respawn;
  logic [2:0]      ghost_eaten;
  logic [1:0]      lives;

  game_state_ctrl #(.POWER_FRAMES(PF), .DYING_FRAMES(DF), .LIVES_INIT(LI)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start),
    .pacmanX(pacmanX), .pacmanY(pacmanY),
    .ghost_redX(ghost_redX), .ghost_redY(ghost_redY),
    .ghost_greenX(ghost_greenX), .ghost_greenY(ghost_greenY),
    .ghost_aquaX(ghost_aquaX), .ghost_aquaY(ghost_aquaY),
    .fruit_location(fruit_location),
    .death(death), .reversal(reversal), .closePacman(closePacman),
    .first_on(first_on), .second_on(second_on), .third_on(third_on),
    .respawn(respawn), .ghost_eaten(ghost_eaten), .lives(lives)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int gpos[8];   // pac x,y  red x,y  green x,y  aqua x,y
  int fpos[6];   // X0,Y0,X1,Y1,X2,Y2

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_inputs();
    pacmanX = 10'(gpos[0]); pacmanY = 10'(gpos[1]);
    ghost_redX = 10'(gpos[2]); ghost_redY = 10'(gpos[3]);
    ghost_greenX = 10'(gpos[4]); ghost_greenY = 10'(gpos[5]);
    ghost_aquaX = 10'(gpos[6]); ghost_aquaY = 10'(gpos[7]);
    fruit_location = {10'(fpos[0]), 10'(fpos[1]), 10'(fpos[2]), 10'(fpos[3]), 10'(fpos[4]), 10'(fpos[5])};
  endtask

  task automatic park_ghosts();
    gpos[2] = 800; gpos[3] = 800; gpos[4] = 800; gpos[5] = 700; gpos[6] = 700; gpos[7] = 800;
  endtask

  // One frame: inputs applied, one Clk with frame_tick=1, sample at the following negedge
  task automatic tick(input logic st);
    @(negedge Clk);
    push_inputs();
    start = st;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    m_reset();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lives"}, lives, 0);
    chk({tag, "_death"}, death, 0);
    chk({tag, "_reversal"}, reversal, 0);
    chk({tag, "_close"}, closePacman, 0);
    chk({tag, "_fruits"}, {first_on, second_on, third_on}, 0);
    chk({tag, "_respawn"}, respawn, 0);
    chk({tag, "_eaten"}, ghost_eaten, 0);
  endtask

  // ---------------- reference model (timestamps instead of down-counters) --------
  localparam int M_IDLE = 0, M_PLAY = 1, M_POWER = 2, M_DYING = 3, M_OVER = 4;
  int m_mode, m_lives, m_n, m_power_until, m_dying_until, m_active;
  bit m_close, m_resp;
  bit [2:0] m_on, m_eaten;   // m_on[i] = fruit i present

  function automatic bit near(input int ax, input int ay, input int bx, input int by);
    return (ax - bx < 8) && (bx - ax < 8) && (ay - by < 8) && (by - ay < 8);
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE; m_lives = 0; m_n = 0; m_power_until = 0; m_dying_until = 0;
    m_active = 0; m_close = 0; m_resp = 0; m_on = 0; m_eaten = 0;
  endtask

  task automatic m_tick(input bit st);
    bit [2:0] fh, gh, eat;
    for (int i = 0; i < 3; i++) begin
      fh[i] = near(gpos[0], gpos[1], fpos[2*i], fpos[2*i+1]);
      gh[i] = near(gpos[0], gpos[1], gpos[2+2*i], gpos[3+2*i]);
    end
    m_resp = 0; m_eaten = 0;
    case (m_mode)
      M_IDLE, M_OVER: if (st) begin
        m_mode = M_PLAY; m_on = 3'b111; m_lives = LI; m_active = 0; m_close = 0; m_resp = 1;
      end
      M_PLAY, M_POWER: begin
        if (m_active % 8 == 7) m_close = !m_close;
        m_active++;
        eat = fh & m_on;
        m_on = m_on & ~eat;
        if (eat != 0) begin
          m_mode = M_POWER; m_power_until = m_n + PF; m_eaten = gh;
        end else if (m_mode == M_POWER) begin
          m_eaten = gh;
          if (m_n >= m_power_until) m_mode = M_PLAY;
        end else if (gh != 0) begin
          m_mode = M_DYING; m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          m_dying_until = m_n + DF; m_close = 0;
        end
      end
      M_DYING: if (m_n >= m_dying_until) begin
        if (m_lives == 0) m_mode = M_OVER;
        else begin m_mode = M_PLAY; m_resp = 1; end
      end
      default: ;
    endcase
    m_n++;
  endtask

  function automatic bit m_reversal();
    int left;
    if (m_mode != M_POWER) return 0;
    left = m_power_until - m_n;   // m_n already advanced past the current frame
`ifdef POWER_BLINK_EN
    return (left >= 64) || (((left / 8) % 2) == 1);
`else
    return left >= 0;
`endif
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       st;
    int         px, py, rx, ry, gx, gy, ax, ay;
    logic [2:0] fr;
    logic       rev;
    logic [2:0] eat;
    logic [1:0] lv;
    logic       rsp;
  } vec_t;
  vec_t vt[11];

  task automatic wait_event(input bit want_death, output int found, output int resp_cnt);
    found = -1; resp_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      tick(1'b0);
      if (respawn) resp_cnt++;
      if (want_death ? death : respawn) begin found = i; break; end
    end
  endtask

  int found, rcnt, rev_frames;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1,   0,   0, 800, 800, 800, 700, 700, 800, 3'b111, 1'b0, 3'b000, 2'd3, 1'b1};
    vt[1]  = '{1'b0,  50,  50, 800, 800, 800, 700, 700, 800, 3'b111, 1'b0, 3'b000, 2'd3, 1'b0};
    vt[2]  = '{1'b0, 100, 100, 800, 800, 800, 700, 700, 800, 3'b011, 1'b1, 3'b000, 2'd3, 1'b0};
    vt[3]  = '{1'b0, 100, 100, 800, 800, 800, 700, 700, 800, 3'b011, 1'b1, 3'b000, 2'd3, 1'b0};
    vt[4]  = '{1'b0, 300, 300, 800, 800, 307, 293, 700, 800, 3'b001, 1'b1, 3'b010, 2'd3, 1'b0};
    vt[5]  = '{1'b0, 300, 300, 308, 300, 800, 700, 700, 800, 3'b001, 1'b1, 3'b000, 2'd3, 1'b0};
    vt[6]  = '{1'b0, 300, 300, 292, 300, 800, 700, 700, 800, 3'b001, 1'b1, 3'b000, 2'd3, 1'b0};
    vt[7]  = '{1'b0, 300, 300, 293, 307, 800, 700, 700, 800, 3'b001, 1'b1, 3'b001, 2'd3, 1'b0};
    vt[8]  = '{1'b0, 300, 300, 300, 300, 800, 700, 300, 300, 3'b001, 1'b1, 3'b101, 2'd3, 1'b0};
    vt[9]  = '{1'b0, 600,  40, 800, 800, 800, 700, 700, 800, 3'b000, 1'b1, 3'b000, 2'd3, 1'b0};
    vt[10] = '{1'b0, 600,  40, 800, 800, 800, 700, 700, 800, 3'b000, 1'b1, 3'b000, 2'd3, 1'b0};

    gpos[0] = 0; gpos[1] = 0; park_ghosts();
    fpos = '{104, 96, 300, 300, 600, 40};
    push_inputs();
    #1 chk_reset_vals("in_reset");
    do_reset();
    tick(1'b0);
    chk_reset_vals("idle_no_start");

    for (int i = 0; i < 11; i++) begin
      gpos = '{vt[i].px, vt[i].py, vt[i].rx, vt[i].ry, vt[i].gx, vt[i].gy, vt[i].ax, vt[i].ay};
      tick(vt[i].st);
      chk($sformatf("vec%0d_fruits", i), {first_on, second_on, third_on}, vt[i].fr);
      chk($sformatf("vec%0d_reversal", i), reversal, vt[i].rev);
      chk($sformatf("vec%0d_eaten", i), ghost_eaten, vt[i].eat);
      chk($sformatf("vec%0d_lives", i), lives, vt[i].lv);
      chk($sformatf("vec%0d_respawn", i), respawn, vt[i].rsp);
      @(negedge Clk);
      chk($sformatf("vec%0d_pulse_clear", i), {respawn, ghost_eaten}, 0);
    end

    // Power mode duration from a single fruit hit
    do_reset();
    gpos[0] = 10; gpos[1] = 10; park_ghosts();
    fpos = '{104, 96, 1000, 1000, 1000, 1000};
    tick(1'b1);
    gpos[0] = 100; gpos[1] = 100;
    tick(1'b0);
    chk("powerA_first_on", first_on, 0);
    rev_frames = reversal ? 1 : 0;
    gpos[0] = 10; gpos[1] = 10;
    for (int i = 0; i < 400; i++) begin
      tick(1'b0);
      if (!reversal) break;
      rev_frames++;
    end
    chk("powerA_frames", rev_frames, PF);

    // Three deaths, game over, restart
    do_reset();
    gpos[0] = 100; gpos[1] = 100; park_ghosts();
    fpos = '{1000, 1000, 1000, 1000, 1000, 1000};
    tick(1'b1);
    for (int d = 1; d <= 3; d++) begin
      gpos[2] = 107; gpos[3] = 100;
      tick(1'b0);
      chk($sformatf("death%0d_lives", d), lives, 3 - d);
      chk($sformatf("death%0d_reversal", d), reversal, 0);
      park_ghosts();
      wait_event(d == 3, found, rcnt);
      chk($sformatf("death%0d_dying_frames", d), found, DF);
      chk($sformatf("death%0d_respawns", d), rcnt, (d == 3) ? 0 : 1);
    end
    chk("over_death", death, 1);
    tick(1'b1);
    chk("restart_death", death, 0);
    chk("restart_lives", lives, 3);
    chk("restart_respawn", respawn, 1);
    chk("restart_fruits", {first_on, second_on, third_on}, 3'b111);

    // Reset in the middle of DYING
    do_reset();
    park_ghosts();
    tick(1'b1);
    gpos[2] = 107; gpos[3] = 100;
    tick(1'b0);
    park_ghosts();
    repeat (30) tick(1'b0);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 chk_reset_vals("midreset");
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    rcnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1'b0);
      if (respawn) rcnt++;
    end
    chk("midreset_no_respawn", rcnt, 0);
    chk_reset_vals("midreset_after");

    // Randomized run against the reference model
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      bit st;
      gpos[0] = 100 + int'($urandom_range(0, 60));
      gpos[1] = 100 + int'($urandom_range(0, 60));
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 24) == 0) begin
          gpos[2+2*g] = gpos[0] + int'($urandom_range(0, 18)) - 9;
          gpos[3+2*g] = gpos[1] + int'($urandom_range(0, 18)) - 9;
        end else begin
          gpos[2+2*g] = 900; gpos[3+2*g] = 900;
        end
      end
      for (int f = 0; f < 3; f++) begin
        if ($urandom_range(0, 39) == 0) begin
          fpos[2*f]   = gpos[0] + int'($urandom_range(0, 18)) - 9;
          fpos[2*f+1] = gpos[1] + int'($urandom_range(0, 18)) - 9;
        end else begin
          fpos[2*f] = 1000; fpos[2*f+1] = 1000;
        end
      end
      st = ($urandom_range(0, 9) == 0);
      tick(st);
      m_tick(st);
      chk("rnd_lives", lives, m_lives);
      chk("rnd_fruits", {first_on, second_on, third_on}, {m_on[0], m_on[1], m_on[2]});
      chk("rnd_reversal", reversal, m_reversal());
      chk("rnd_death", death, m_mode == M_OVER);
      chk("rnd_close", closePacman, m_close);
      chk("rnd_respawn", respawn, m_resp);
      chk("rnd_eaten", ghost_eaten, m_eaten);
      @(negedge Clk);
      chk("rnd_pulse_clear", {respawn, ghost_eaten}, 0);
      chk("rnd_hold_lives", lives, m_lives);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
